mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/risc_pkg.sv | 16 +
 rtl/mem_arbiter.sv | 111 +++++++++++
 tb/tb_mem_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/risc_pkg.sv
// Shared definitions for the memory arbiter slice.
//   RISC_ADDR_W : default word-address width of the shared RAM2Kx32
//   RISC_DATA_W : default data width
//   port_sel_e  : which requester owns an access (none, fetch, data)
package risc_pkg;

    localparam int RISC_ADDR_W = 11;
    localparam int RISC_DATA_W = 32;

    typedef enum logic [1:0] {
        PORT_NONE = 2'd0,
        PORT_IF   = 2'd1,
        PORT_DM   = 2'd2
    } port_sel_e;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous RAM.
// The data port normally wins; the fetch port is forced through after
// STARVE_MAX consecutive denials. One access per cycle, read data returns
// one cycle after the grant.
// Ports:
//   clk, rst                      clock, async active-high reset
//   if_req/if_addr                fetch read request
//   if_gnt/if_rvalid/if_rdata     fetch accept and read return
//   dm_req/dm_we/dm_addr/dm_wdata data request (we=1 store, 0 load)
//   dm_gnt/dm_rvalid/dm_rdata     data accept and load return
//   mem_cen/mem_wen/mem_oen       active-low RAM controls
//   mem_a/mem_d/mem_q             RAM address, write data, read data
module mem_arbiter
    import risc_pkg::*;
#(
    parameter int ADDR_W     = RISC_ADDR_W,
    parameter int DATA_W     = RISC_DATA_W,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_cen,
    output logic              mem_wen,
    output logic              mem_oen,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_d,
    input  logic [DATA_W-1:0] mem_q
);

    localparam int CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    port_sel_e         r_owner;
    logic [CNT_W-1:0]  r_starve_cnt;
    logic [DATA_W-1:0] r_if_hold;
    logic [DATA_W-1:0] r_dm_hold;

    logic      w_if_win;
    port_sel_e w_rd_sel;

    // Grants are gated by rst so nothing reaches the RAM while in reset.
    always_comb begin
        w_if_win = if_req && (!dm_req || (r_starve_cnt == STARVE_LIM));
        if_gnt   = !rst && w_if_win;
        dm_gnt   = !rst && dm_req && !w_if_win;

        mem_oen = 1'b0;
        mem_cen = !(if_gnt || dm_gnt);
        mem_wen = dm_gnt ? !dm_we : 1'b1;
        mem_a   = dm_gnt ? dm_addr : if_addr;
        mem_d   = dm_wdata;

        // Stores produce no read return, so they leave no owner behind.
        w_rd_sel = PORT_NONE;
        if (if_gnt) begin
            w_rd_sel = PORT_IF;
        end else if (dm_gnt && !dm_we) begin
            w_rd_sel = PORT_DM;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner      <= PORT_NONE;
            r_starve_cnt <= '0;
            r_if_hold    <= '0;
            r_dm_hold    <= '0;
        end else begin
            r_owner <= w_rd_sel;

            if (if_req && !if_gnt) begin
                if (r_starve_cnt != STARVE_LIM) begin
                    r_starve_cnt <= r_starve_cnt + CNT_W'(1);
                end
            end else begin
                r_starve_cnt <= '0;
            end

            // Capture the returned word at the end of its valid cycle so
            // rdata keeps showing it once rvalid drops.
            if (r_owner == PORT_IF) begin
                r_if_hold <= mem_q;
            end
            if (r_owner == PORT_DM) begin
                r_dm_hold <= mem_q;
            end
        end
    end

    // mem_q is only valid after the edge that sampled the read, so the
    // valid cycle passes it straight through.
    always_comb begin
        if_rvalid = (r_owner == PORT_IF);
        dm_rvalid = (r_owner == PORT_DM);
        if_rdata  = if_rvalid ? mem_q : r_if_hold;
        dm_rdata  = dm_rvalid ? mem_q : r_dm_hold;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int AW = 11;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_gnt;
    logic          dm_rvalid;
    logic [DW-1:0] dm_rdata;
    logic          mem_cen;
    logic          mem_wen;
    logic          mem_oen;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_d;
    logic [DW-1:0] mem_q;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(3)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_oen(mem_oen),
        .mem_a(mem_a), .mem_d(mem_d), .mem_q(mem_q)
    );

    always #5 clk = ~clk;

    // RAM2Kx32 behaviour: synchronous, q updates after the sampling edge.
    logic [DW-1:0] ram   [0:2047];
    logic [DW-1:0] model [0:2047];
    always @(posedge clk) begin
        if (!mem_cen) begin
            if (!mem_wen) ram[mem_a] <= mem_d;
            else          mem_q      <= ram[mem_a];
        end
    end

    // kind: 0 = no return expected, 1 = fetch return, 2 = data return
    typedef struct {
        logic [1:0]    kind;
        logic [DW-1:0] data;
    } exp_t;
    exp_t exp_q[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic ir, input logic [AW-1:0] ia,
                         input logic dr, input logic dw,
                         input logic [AW-1:0] da, input logic [DW-1:0] dd);
        if_req = ir; if_addr = ia;
        dm_req = dr; dm_we = dw; dm_addr = da; dm_wdata = dd;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 11'd5, 1'b1, 1'b0, 11'd7, 32'h0);
        n_vec++;
        if ({if_gnt, dm_gnt, if_rvalid, dm_rvalid} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_gnt_rvalid: got %b want 0000", {if_gnt, dm_gnt, if_rvalid, dm_rvalid});
        end
        n_vec++;
        if ({mem_cen, mem_wen, mem_oen} !== 3'b110) begin
            n_err++;
            $display("FAIL reset_mem_ctl: got %b want 110", {mem_cen, mem_wen, mem_oen});
        end
        tick();
        n_vec++;
        if (if_rdata !== 32'h0 || dm_rdata !== 32'h0 || if_rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_rdata: got if=%h dm=%h v=%b want 0", if_rdata, dm_rdata, if_rvalid);
        end
        drive(1'b0, 11'd0, 1'b0, 1'b0, 11'd0, 32'h0);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_fetch();
        exp_t e;
        drive(1'b1, 11'd5, 1'b0, 1'b0, 11'd0, 32'h0);
        n_vec++;
        if ({if_gnt, dm_gnt, mem_cen, mem_wen} !== 4'b1001 || mem_a !== 11'd5) begin
            n_err++;
            $display("FAIL fetch_grant: got gnt=%b%b cen=%b wen=%b a=%0d want 10 0 1 5",
                     if_gnt, dm_gnt, mem_cen, mem_wen, mem_a);
        end
        exp_q.push_back('{kind: 2'd1, data: model[5]});
        tick();
        drive(1'b0, 11'd0, 1'b0, 1'b0, 11'd0, 32'h0);
        e = exp_q.pop_front();
        n_vec++;
        if ({dm_rvalid, if_rvalid} !== e.kind || if_rdata !== e.data) begin
            n_err++;
            $display("FAIL fetch_return: got v=%b%b d=%h want kind %0d d=%h",
                     dm_rvalid, if_rvalid, if_rdata, e.kind, e.data);
        end
        tick();
        n_vec++;
        if (if_rvalid !== 1'b0 || if_rdata !== 32'h1234) begin
            n_err++;
            $display("FAIL fetch_hold: got v=%b d=%h want 0 00001234", if_rvalid, if_rdata);
        end
    endtask

    task automatic test_store_load();
        exp_t e;
        drive(1'b0, 11'd0, 1'b1, 1'b1, 11'd7, 32'hA5A5A5A5);
        n_vec++;
        if ({dm_gnt, mem_cen, mem_wen} !== 3'b100 || mem_a !== 11'd7 || mem_d !== 32'hA5A5A5A5) begin
            n_err++;
            $display("FAIL store_ctl: got gnt=%b cen=%b wen=%b a=%0d d=%h want 1 0 0 7 a5a5a5a5",
                     dm_gnt, mem_cen, mem_wen, mem_a, mem_d);
        end
        model[7] = 32'hA5A5A5A5;
        exp_q.push_back('{kind: 2'd0, data: 32'h0});
        tick();
        drive(1'b0, 11'd0, 1'b1, 1'b0, 11'd7, 32'h0);
        e = exp_q.pop_front();
        n_vec++;
        if ({dm_rvalid, if_rvalid} !== e.kind) begin
            n_err++;
            $display("FAIL store_no_rvalid: got %b%b want kind %0d", dm_rvalid, if_rvalid, e.kind);
        end
        n_vec++;
        if (dm_gnt !== 1'b1 || mem_wen !== 1'b1) begin
            n_err++;
            $display("FAIL load_ctl: got gnt=%b wen=%b want 1 1", dm_gnt, mem_wen);
        end
        exp_q.push_back('{kind: 2'd2, data: model[7]});
        tick();
        drive(1'b0, 11'd0, 1'b0, 1'b0, 11'd0, 32'h0);
        e = exp_q.pop_front();
        n_vec++;
        if ({dm_rvalid, if_rvalid} !== e.kind || dm_rdata !== e.data) begin
            n_err++;
            $display("FAIL load_return: got v=%b%b d=%h want kind %0d d=%h",
                     dm_rvalid, if_rvalid, dm_rdata, e.kind, e.data);
        end
        tick();
        n_vec++;
        if (dm_rvalid !== 1'b0 || dm_rdata !== 32'hA5A5A5A5) begin
            n_err++;
            $display("FAIL load_hold: got v=%b d=%h want 0 a5a5a5a5", dm_rvalid, dm_rdata);
        end
    endtask

    task automatic test_starve();
        logic [1:0] pat [8] = '{2'd2, 2'd2, 2'd2, 2'd1, 2'd2, 2'd2, 2'd2, 2'd1};
        exp_t e;
        drive(1'b1, 11'd20, 1'b1, 1'b0, 11'd10, 32'h0);
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if ({dm_gnt, if_gnt} !== pat[i]) begin
                n_err++;
                $display("FAIL starve_pattern[%0d]: got dm/if=%b%b want %b", i, dm_gnt, if_gnt, pat[i]);
            end
            exp_q.push_back('{kind: pat[i], data: (pat[i] == 2'd1) ? model[20] : model[10]});
            tick();
            e = exp_q.pop_front();
            n_vec++;
            if ({dm_rvalid, if_rvalid} !== e.kind ||
                (e.kind == 2'd1 && if_rdata !== e.data) ||
                (e.kind == 2'd2 && dm_rdata !== e.data)) begin
                n_err++;
                $display("FAIL starve_return[%0d]: got v=%b%b if=%h dm=%h want kind %0d d=%h",
                         i, dm_rvalid, if_rvalid, if_rdata, dm_rdata, e.kind, e.data);
            end
        end
        drive(1'b0, 11'd0, 1'b0, 1'b0, 11'd0, 32'h0);
        tick();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int i = 1; i <= 4; i++) begin
            if (i <= 3) begin
                drive(1'b0, 11'd0, 1'b1, 1'b0, AW'(i), 32'h0);
                exp_q.push_back('{kind: 2'd2, data: model[i]});
            end else begin
                drive(1'b0, 11'd0, 1'b0, 1'b0, 11'd0, 32'h0);
                exp_q.push_back('{kind: 2'd0, data: 32'h0});
            end
            tick();
            e = exp_q.pop_front();
            n_vec++;
            if ({dm_rvalid, if_rvalid} !== e.kind || (e.kind == 2'd2 && dm_rdata !== e.data)) begin
                n_err++;
                $display("FAIL b2b_return[%0d]: got v=%b%b d=%h want kind %0d d=%h",
                         i, dm_rvalid, if_rvalid, dm_rdata, e.kind, e.data);
            end
        end
    endtask

    task automatic test_reset_mid();
        // Read granted in the cycle reset asserts must not return.
        drive(1'b1, 11'd5, 1'b0, 1'b0, 11'd0, 32'h0);
        rst = 1'b1;
        #1;
        tick();
        drive(1'b0, 11'd0, 1'b0, 1'b0, 11'd0, 32'h0);
        rst = 1'b0;
        #1;
        tick();
        n_vec++;
        if (if_rvalid !== 1'b0 || dm_rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_same_cycle: got v=%b%b want 00", dm_rvalid, if_rvalid);
        end
        // Reset landing in the return cycle of a fetch.
        drive(1'b1, 11'd5, 1'b0, 1'b0, 11'd0, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_cen, mem_wen} !== 6'b000011 ||
            if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin
            n_err++;
            $display("FAIL rst_mid_outputs: got %b if=%h dm=%h want 000011 0 0",
                     {if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_cen, mem_wen}, if_rdata, dm_rdata);
        end
        @(negedge clk);
        tick();
        drive(1'b1, 11'd6, 1'b0, 1'b0, 11'd0, 32'h0);
        rst = 1'b0;
        #1;
        n_vec++;
        if (if_gnt !== 1'b1 || if_rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_release_gnt: got gnt=%b v=%b want 1 0", if_gnt, if_rvalid);
        end
        tick();
        drive(1'b0, 11'd0, 1'b0, 1'b0, 11'd0, 32'h0);
        n_vec++;
        if (if_rvalid !== 1'b1 || if_rdata !== model[6]) begin
            n_err++;
            $display("FAIL rst_release_return: got v=%b d=%h want 1 %h", if_rvalid, if_rdata, model[6]);
        end
        tick();
    endtask

    task automatic test_idle();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, AW'(i), 1'b0, 1'b1, AW'(i), 32'hDEADBEEF);
            n_vec++;
            if ({mem_cen, mem_wen, if_gnt, dm_gnt} !== 4'b1100) begin
                n_err++;
                $display("FAIL idle_ctl[%0d]: got cen/wen/gnt=%b want 1100", i, {mem_cen, mem_wen, if_gnt, dm_gnt});
            end
            tick();
        end
        for (int i = 0; i < 16; i++) begin
            n_vec++;
            if (ram[i] !== model[i]) begin
                n_err++;
                $display("FAIL idle_ram[%0d]: got %h want %h", i, ram[i], model[i]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) begin
            model[i] = 32'hC0DE0000 ^ (i * 32'h00010003);
        end
        model[5] = 32'h1234;
        for (int i = 0; i < 2048; i++) ram[i] = model[i];
        mem_q = 32'h0;
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        @(negedge clk);
        test_reset();
        test_fetch();
        test_store_load();
        test_starve();
        test_back_to_back();
        test_reset_mid();
        test_idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
